// File: rtl/yuv_rd_arbiter.sv
// Shares one fixed-length YUV burst-read port between NUM_REQ requesters.
// Round-robin by default; define YUV_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module yuv_rd_arbiter #(
   parameter int NUM_REQ     = 7,
   parameter int ADDR_WIDTH  = 32,
   parameter int BURST_LEN   = 64,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                          ap_clk,
   input  logic                          ap_rst,
   input  logic [NUM_REQ-1:0]            req_vld,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   output logic [NUM_REQ-1:0]            req_ack,
   output logic [NUM_REQ-1:0]            rsp_data_vld,
   output logic [7:0]                    rsp_data,
   output logic [NUM_REQ-1:0]            rsp_done,
   output logic [NUM_REQ-1:0]            rsp_err,
   output logic                          busy,
   output logic                          rd_yuv_start,
   output logic [31:0]                   rd_yuv_addr,
   input  logic                          rd_yuv_data_vld,
   input  logic [7:0]                    rd_yuv_data
);

   localparam int IW  = $clog2(NUM_REQ);
   localparam int BCW = $clog2(BURST_LEN + 1);
   localparam int TCW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [BCW-1:0] BYTE_LAST = BCW'(BURST_LEN - 1);
   localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CYC - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   logic [1:0]            state;
   logic                  issue_ph;
   logic [IW-1:0]         grant;
   logic [BCW-1:0]        byte_cnt;
   logic [TCW-1:0]        to_cnt;
   logic                  sel_found;
   logic [IW-1:0]         sel_idx;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [31:0]           sel_addr32;
   logic [NUM_REQ-1:0]    sel_oh;
   logic [NUM_REQ-1:0]    grant_oh;
   logic                  burst_end;

`ifdef YUV_ARB_FIXED_PRIO_EN
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!sel_found && req_vld[IW'(k)]) begin
            sel_found = 1'b1;
            sel_idx   = IW'(k);
         end
      end
   end
`else
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] scan_idx;
   int            scan_pos;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      sel_found = 1'b0;
      sel_idx   = '0;
      scan_pos  = 0;
      scan_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_pos = int'(rr_ptr) + k;
         if (scan_pos >= NUM_REQ) scan_pos = scan_pos - NUM_REQ;
         scan_idx = IW'(scan_pos);
         if (!sel_found && req_vld[scan_idx]) begin
            sel_found = 1'b1;
            sel_idx   = scan_idx;
         end
      end
   end

   // Pointer moves past the served requester on both completion and timeout.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst)         rr_ptr <= '0;
      else if (burst_end) rr_ptr <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
   end
`endif

   assign sel_addr = req_addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
   assign sel_oh   = NUM_REQ'(1) << sel_idx;
   assign grant_oh = NUM_REQ'(1) << grant;

   generate
      if (ADDR_WIDTH >= 32) begin : g_addr_trunc
         assign sel_addr32 = sel_addr[31:0];
      end else begin : g_addr_zext
         assign sel_addr32 = {{(32 - ADDR_WIDTH){1'b0}}, sel_addr};
      end
   endgenerate

   // A byte arriving on the timeout cycle takes precedence over the timeout.
   assign burst_end = (state == ST_WAIT) &&
                      (rd_yuv_data_vld ? (byte_cnt == BYTE_LAST) : (to_cnt == TO_LAST));

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state        <= ST_IDLE;
         issue_ph     <= 1'b0;
         grant        <= '0;
         byte_cnt     <= '0;
         to_cnt       <= '0;
         req_ack      <= '0;
         rsp_data_vld <= '0;
         rsp_data     <= '0;
         rsp_done     <= '0;
         rsp_err      <= '0;
         busy         <= 1'b0;
         rd_yuv_start <= 1'b0;
         rd_yuv_addr  <= '0;
      end else begin
         // NOTE: pulse outputs fall back to 0 every cycle; states below only raise them.
         req_ack      <= '0;
         rsp_data_vld <= '0;
         rsp_done     <= '0;
         rsp_err      <= '0;
         case (state)
            ST_IDLE: begin
               if (sel_found) begin
                  state        <= ST_ISSUE;
                  issue_ph     <= 1'b0;
                  grant        <= sel_idx;
                  byte_cnt     <= '0;
                  to_cnt       <= '0;
                  req_ack      <= sel_oh;
                  busy         <= 1'b1;
                  rd_yuv_start <= 1'b1;
                  rd_yuv_addr  <= sel_addr32;
               end
            end
            ST_ISSUE: begin
               if (!issue_ph) begin
                  issue_ph <= 1'b1;
               end else begin
                  state        <= ST_WAIT;
                  rd_yuv_start <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (rd_yuv_data_vld) begin
                  rsp_data     <= rd_yuv_data;
                  rsp_data_vld <= grant_oh;
                  byte_cnt     <= byte_cnt + 1'b1;
                  to_cnt       <= '0;
                  if (burst_end) rsp_done <= grant_oh;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
                  if (burst_end) rsp_err <= grant_oh;
               end
               if (burst_end) begin
                  state       <= ST_IDLE;
                  busy        <= 1'b0;
                  rd_yuv_addr <= '0;
               end
            end
            default: begin
               state        <= ST_IDLE;
               busy         <= 1'b0;
               rd_yuv_start <= 1'b0;
               rd_yuv_addr  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_yuv_rd_arbiter.sv
// Directed bench for yuv_rd_arbiter: single burst, contention, wrap, timeout, stray data, reset mid-burst.
// Grant-order expectations follow YUV_ARB_FIXED_PRIO_EN when that macro is defined.
module tb_yuv_rd_arbiter;

   localparam int NR = 7;
   localparam int AW = 32;
   localparam int BL = 64;
   localparam int TO = 16;

   logic              ap_clk = 1'b0;
   logic              ap_rst;
   logic [NR-1:0]     req_vld;
   logic [NR*AW-1:0]  req_addr;
   logic [NR-1:0]     req_ack;
   logic [NR-1:0]     rsp_data_vld;
   logic [7:0]        rsp_data;
   logic [NR-1:0]     rsp_done;
   logic [NR-1:0]     rsp_err;
   logic              busy;
   logic              rd_yuv_start;
   logic [31:0]       rd_yuv_addr;
   logic              rd_yuv_data_vld;
   logic [7:0]        rd_yuv_data;

   int n_checks = 0;
   int n_pass   = 0;
   int last_wait;
   int cont_order [4];

   yuv_rd_arbiter #(
      .NUM_REQ     (NR),
      .ADDR_WIDTH  (AW),
      .BURST_LEN   (BL),
      .TIMEOUT_CYC (TO)
   ) dut (
      .ap_clk          (ap_clk),
      .ap_rst          (ap_rst),
      .req_vld         (req_vld),
      .req_addr        (req_addr),
      .req_ack         (req_ack),
      .rsp_data_vld    (rsp_data_vld),
      .rsp_data        (rsp_data),
      .rsp_done        (rsp_done),
      .rsp_err         (rsp_err),
      .busy            (busy),
      .rd_yuv_start    (rd_yuv_start),
      .rd_yuv_addr     (rd_yuv_addr),
      .rd_yuv_data_vld (rd_yuv_data_vld),
      .rd_yuv_data     (rd_yuv_data)
   );

   always #5 ap_clk = ~ap_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200us");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [NR-1:0] oh(input int i);
      return NR'(1) << i;
   endfunction

   function automatic logic [31:0] addr_of(input int i);
      return 32'hA000_0000 + 32'(i) * 32'h100;
   endfunction

   task automatic step();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"}, 64'({req_ack, rsp_data_vld, rsp_done, rsp_err, rsp_data, busy, rd_yuv_start}), 64'd0);
      check({tag, "_addr"}, 64'(rd_yuv_addr), 64'd0);
   endtask

   task automatic reset_dut();
      ap_rst          = 1'b1;
      req_vld         = '0;
      rd_yuv_data_vld = 1'b0;
      step();
      step();
      ap_rst = 1'b0;
      step();
   endtask

   // Waits for the grant, checks both ISSUE cycles, then returns nbytes bytes.
   task automatic serve(input int g, input logic [31:0] a, input bit drop, input bit stray, input int nbytes);
      bit         got;
      logic [7:0] b;
      got       = 1'b0;
      last_wait = 0;
      if (stray) rd_yuv_data_vld = 1'b1;
      for (int k = 0; k < 6 && !got; k++) begin
         step();
         last_wait++;
         if (req_ack != '0) got = 1'b1;
      end
      check("ack", 64'(req_ack), 64'(oh(g)));
      check("start1", 64'(rd_yuv_start), 64'd1);
      check("addr", 64'(rd_yuv_addr), 64'(a));
      check("busy_issue", 64'(busy), 64'd1);
      check("no_vld_issue1", 64'(rsp_data_vld), 64'd0);
      if (drop) req_vld[g] = 1'b0;
      step();
      check("ack_once", 64'(req_ack), 64'd0);
      check("start2", 64'(rd_yuv_start), 64'd1);
      check("no_vld_issue2", 64'(rsp_data_vld), 64'd0);
      step();
      check("start_end", 64'(rd_yuv_start), 64'd0);
      check("no_vld_wait0", 64'(rsp_data_vld), 64'd0);
      check("addr_hold", 64'(rd_yuv_addr), 64'(a));
      for (int i = 0; i < nbytes; i++) begin
         b               = 8'(i * 7 + g * 16 + 1);
         rd_yuv_data_vld = 1'b1;
         rd_yuv_data     = b;
         step();
         check("byte_vld", 64'(rsp_data_vld), 64'(oh(g)));
         check("byte_data", 64'(rsp_data), 64'(b));
         check("done", 64'(rsp_done), (i == BL - 1) ? 64'(oh(g)) : 64'd0);
         check("no_err", 64'(rsp_err), 64'd0);
      end
      rd_yuv_data_vld = 1'b0;
      if (nbytes == BL) begin
         check("busy_end", 64'(busy), 64'd0);
         check("addr_clear", 64'(rd_yuv_addr), 64'd0);
      end
   endtask

   initial begin
      logic [NR-1:0] seen;
`ifdef YUV_ARB_FIXED_PRIO_EN
      cont_order = '{0, 0, 0, 0};
`else
      cont_order = '{0, 2, 6, 0};
`endif
      ap_rst          = 1'b1;
      req_vld         = '0;
      rd_yuv_data_vld = 1'b0;
      rd_yuv_data     = '0;
      for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = addr_of(i);
      step();
      step();
      check_all_zero("reset");
      ap_rst = 1'b0;
      step();

      // Single request from requester 2.
      req_addr[2*AW +: AW] = 32'h0000_1000;
      req_vld = 7'b0000100;
      serve(2, 32'h0000_1000, 1'b1, 1'b0, BL);
      check("ack_latency", 64'(last_wait), 64'd1);
      req_addr[2*AW +: AW] = addr_of(2);

      // Contention with requests held.
      reset_dut();
      req_vld = 7'b1000101;
      for (int n = 0; n < 4; n++) serve(cont_order[n], addr_of(cont_order[n]), 1'b0, 1'b0, BL);
      req_vld = '0;

      // Wrap: serve 5, then 0 and 1 pending.
      reset_dut();
      req_vld = 7'b0100000;
      serve(5, addr_of(5), 1'b1, 1'b0, BL);
      req_vld = 7'b0000011;
      serve(0, addr_of(0), 1'b1, 1'b0, BL);
      serve(1, addr_of(1), 1'b1, 1'b0, BL);

      // Timeout after 10 bytes, then a normal burst.
      req_vld = 7'b0001000;
      serve(3, addr_of(3), 1'b1, 1'b0, 10);
      seen = '0;
      repeat (TO - 1) begin
         step();
         seen = seen | rsp_err | rsp_done;
      end
      check("to_early", 64'(seen), 64'd0);
      step();
      check("to_err", 64'(rsp_err), 64'(oh(3)));
      check("to_no_done", 64'(rsp_done), 64'd0);
      check("to_busy", 64'(busy), 64'd0);
      step();
      check("to_err_pulse", 64'(rsp_err), 64'd0);
      req_vld = 7'b0010000;
      serve(4, addr_of(4), 1'b1, 1'b0, BL);

      // Stray strobes in IDLE, ISSUE and after the burst.
      rd_yuv_data_vld = 1'b1;
      step();
      check("stray_idle", 64'(rsp_data_vld), 64'd0);
      req_vld = 7'b0000010;
      serve(1, addr_of(1), 1'b1, 1'b1, BL);
      rd_yuv_data_vld = 1'b1;
      step();
      check("stray_after", 64'(rsp_data_vld), 64'd0);
      rd_yuv_data_vld = 1'b0;
      step();

      // Reset after 20 bytes of a burst.
      req_vld = 7'b0010000;
      serve(4, addr_of(4), 1'b1, 1'b0, 20);
      ap_rst = 1'b1;
      #1;
      check_all_zero("rst_mid");
      step();
      step();
      check_all_zero("rst_hold");
      ap_rst = 1'b0;
      step();
      req_vld = 7'b1000010;
      serve(1, addr_of(1), 1'b1, 1'b0, BL);
      serve(6, addr_of(6), 1'b1, 1'b0, BL);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
